// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
//   arb_state_t       : arbiter state, also the encoding driven on arb_owner
//                       (0 = none, 1 = I-cache, 2 = D-cache)
//   requester_t       : identifies a requester (used for round-robin history)
//   DEFAULT_BURST_LEN : words per cache-line transfer (256-bit line / 32-bit word)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IC   = 2'd1,
    ARB_DC   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } requester_t;

  localparam int DEFAULT_BURST_LEN = 8;

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// mem_arb_beat_cnt: counts completed words of the current burst.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   clr  : clear the count (burst released); wins over inc
//   inc  : one word of the burst completed this cycle
//   last : the word in flight is the final word of the line
module mem_arb_beat_cnt
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache and D-cache.
// Grant is held for a whole line burst so fills/writebacks never interleave.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration on ties
// (otherwise fixed D-cache-over-I-cache priority, no history register).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ic_read/ic_write/ic_addr/
//   ic_wdata/ic_strobe            : I-cache request side (held until ic_valid)
//   ic_valid/ic_rdata             : completion pulse and read data to I-cache
//   dc_*                          : same set for the D-cache
//   mem_read/mem_write/mem_addr/
//   mem_wdata/mem_strobe          : memory request, muxed from the owner
//   mem_valid/mem_rdata           : memory completion pulse (one per word), data
//   arb_owner                     : registered owner (0 none, 1 I, 2 D)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_read,
  input  logic        ic_write,
  output logic        ic_valid,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_rdata,
  input  logic [31:0] ic_wdata,
  input  logic [3:0]  ic_strobe,
  input  logic        dc_read,
  input  logic        dc_write,
  output logic        dc_valid,
  input  logic [31:0] dc_addr,
  output logic [31:0] dc_rdata,
  input  logic [31:0] dc_wdata,
  input  logic [3:0]  dc_strobe,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strobe,
  output logic [1:0]  arb_owner
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic req_ic;
  logic req_dc;
  logic owner_ic;
  logic owner_dc;
  logic owner_req;
  logic final_beat;
  logic release_burst;
  logic grant;
  logic beat_last;

`ifdef MEM_ARB_RR_EN
  requester_t last_served;

  function automatic arb_state_t pick(input logic want_ic, input logic want_dc,
                                      input requester_t last);
    if (want_ic && want_dc) begin
      return (last == REQ_IC) ? ARB_DC : ARB_IC;
    end
    if (want_dc) return ARB_DC;
    if (want_ic) return ARB_IC;
    return ARB_IDLE;
  endfunction
`else
  function automatic arb_state_t pick(input logic want_ic, input logic want_dc);
    if (want_dc) return ARB_DC;
    if (want_ic) return ARB_IC;
    return ARB_IDLE;
  endfunction
`endif

  always_comb begin
    req_ic     = ic_read | ic_write;
    req_dc     = dc_read | dc_write;
    owner_ic   = (state == ARB_IC);
    owner_dc   = (state == ARB_DC);
    owner_req  = (owner_ic & req_ic) | (owner_dc & req_dc);
    final_beat = mem_valid & beat_last;
    // Early end: owner has stopped requesting and nothing is completing.
    release_burst = (owner_ic | owner_dc) & (final_beat | (~owner_req & ~mem_valid));
  end

  // On the final beat the owner's request is still high only because it is
  // being completed right now, so it must not count toward the next grant;
  // otherwise a waiting lower-priority requester would never get in.
  always_comb begin
    logic want_ic;
    logic want_dc;
    want_ic   = req_ic & ~(owner_ic & final_beat);
    want_dc   = req_dc & ~(owner_dc & final_beat);
    state_nxt = state;
    if (state == ARB_IDLE || release_burst) begin
`ifdef MEM_ARB_RR_EN
      state_nxt = pick(want_ic, want_dc, last_served);
`else
      state_nxt = pick(want_ic, want_dc);
`endif
    end
    grant = (state == ARB_IDLE || release_burst) && (state_nxt != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
`ifdef MEM_ARB_RR_EN
      last_served <= REQ_IC;
`endif
    end else begin
      state <= state_nxt;
`ifdef MEM_ARB_RR_EN
      if (grant) begin
        last_served <= (state_nxt == ARB_DC) ? REQ_DC : REQ_IC;
      end
`endif
    end
  end

  assign arb_owner = state;

  mem_arb_beat_cnt #(
    .BURST_LEN(BURST_LEN)
  ) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (release_burst),
    .inc  ((owner_ic | owner_dc) & mem_valid),
    .last (beat_last)
  );

  // Owner mux: memory side follows the owner, completions go only to it.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_strobe = '0;
    ic_valid   = 1'b0;
    ic_rdata   = '0;
    dc_valid   = 1'b0;
    dc_rdata   = '0;
    case (state)
      ARB_IC: begin
        mem_read   = ic_read;
        mem_write  = ic_write;
        mem_addr   = ic_addr;
        mem_wdata  = ic_wdata;
        mem_strobe = ic_strobe;
        ic_valid   = mem_valid;
        ic_rdata   = mem_rdata;
      end
      ARB_DC: begin
        mem_read   = dc_read;
        mem_write  = dc_write;
        mem_addr   = dc_addr;
        mem_wdata  = dc_wdata;
        mem_strobe = dc_strobe;
        dc_valid   = mem_valid;
        dc_rdata   = mem_rdata;
      end
      default: begin
      end
    endcase
  end

  // grant only feeds the round-robin history; keep it observable otherwise.
`ifndef MEM_ARB_RR_EN
  logic grant_unused;
  assign grant_unused = grant;
`endif

endmodule
